// File: rtl/touch_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : touch_key_debounce
//  Brief    : Synchronises and debounces a raw touch-sensor pin, producing a
//             clean level plus one-cycle press, release and long-press events.
//  Revision : 1.0 - initial release
// ============================================================================
module touch_key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned LONG_CYC     = 50_000_000,
    parameter logic        ACTIVE_LVL   = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic touch_key,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);

    localparam logic [DB_W-1:0]   c_db_last   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(LONG_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

    logic              sync1_q;
    logic              sync2_q;
    logic              w_p;

    state_t            state_q,     state_d;
    logic [DB_W-1:0]   db_cnt_q,    db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic              long_done_q, long_done_d;
    logic              key_level_q, key_level_d;
    logic              press_q,     press_d;
    logic              release_q,   release_d;
    logic              long_q,      long_d;

    // Two-flop synchroniser; resets to the idle (untouched) pin level
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= ~ACTIVE_LVL;
            sync2_q <= ~ACTIVE_LVL;
        end else begin
            sync1_q <= touch_key;
            sync2_q <= sync1_q;
        end
    end

    assign w_p = (sync2_q == ACTIVE_LVL);

    // State, counters and registered outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            key_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            key_level_q <= key_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    // Next-state logic; pulses default low so each lasts exactly one cycle
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        key_level_d = key_level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_p) begin
                    state_d  = ST_PRESS_DB;
                    db_cnt_d = '0;
                end
            end

            ST_PRESS_DB: begin
                if (!w_p) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == c_db_last) begin
                    state_d     = ST_HELD;
                    key_level_d = 1'b1;
                    press_d     = 1'b1;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end

            ST_HELD: begin
                if (!w_p) begin
                    state_d  = ST_RELEASE_DB;
                    db_cnt_d = '0;
                end
                // Long-press timing runs only while truly held; once fired it
                // stays latched until the next accepted press.
                if (!long_done_q) begin
                    if (hold_cnt_q == c_hold_last) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end

            ST_RELEASE_DB: begin
                // hold_cnt/long_done are left untouched here so a rejected
                // release bounce resumes long-press timing where it paused.
                if (w_p) begin
                    state_d = ST_HELD;
                end else if (db_cnt_q == c_db_last) begin
                    state_d     = ST_IDLE;
                    key_level_d = 1'b0;
                    release_d   = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign key_level     = key_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule
`default_nettype wire

// File: tb/tb_touch_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_touch_key_debounce
//  Brief    : Directed self-checking bench for touch_key_debounce
//             (DEBOUNCE_CYC=4, LONG_CYC=20) plus an inverted-polarity copy.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_touch_key_debounce;

    logic sys_clk;
    logic sys_rst;
    logic touch_key;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    logic rst_n2;
    logic key_n;
    logic level_n;
    logic press_n;
    logic release_n;
    logic long_n;

    int n_vec;
    int n_err;

    int press_cnt;
    int release_cnt;
    int long_cnt;
    int overlap_cnt;
    int press_n_cnt;
    int release_n_cnt;
    int long_n_cnt;

    int b_p;
    int b_r;
    int b_l;

    touch_key_debounce #(
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (20),
        .ACTIVE_LVL   (1'b1)
    ) u_dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .touch_key     (touch_key),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    touch_key_debounce #(
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (20),
        .ACTIVE_LVL   (1'b0)
    ) u_dut_inv (
        .sys_clk       (sys_clk),
        .sys_rst       (rst_n2),
        .touch_key     (key_n),
        .key_level     (level_n),
        .press_pulse   (press_n),
        .release_pulse (release_n),
        .long_pulse    (long_n)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        press_cnt = 0; release_cnt = 0; long_cnt = 0; overlap_cnt = 0;
        press_n_cnt = 0; release_n_cnt = 0; long_n_cnt = 0;
    end

    // Tally every pulse mid-cycle, and flag any cycle with two pulses high
    always @(negedge sys_clk) begin
        if (press_pulse)   press_cnt   = press_cnt + 1;
        if (release_pulse) release_cnt = release_cnt + 1;
        if (long_pulse)    long_cnt    = long_cnt + 1;
        if ((press_pulse && release_pulse) || (press_pulse && long_pulse) ||
            (release_pulse && long_pulse))
            overlap_cnt = overlap_cnt + 1;
        if (press_n)   press_n_cnt   = press_n_cnt + 1;
        if (release_n) release_n_cnt = release_n_cnt + 1;
        if (long_n)    long_n_cnt    = long_n_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle just after it
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        sys_rst   = 1'b1;
        touch_key = 1'b0;
        rst_n2    = 1'b1;
        key_n     = 1'b1;

        // ---- reset state
        repeat (3) tick();
        chk("rst_level",   {31'd0, key_level},     32'd0);
        chk("rst_press",   {31'd0, press_pulse},   32'd0);
        chk("rst_release", {31'd0, release_pulse}, 32'd0);
        chk("rst_long",    {31'd0, long_pulse},    32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (2) tick();

        // ---- clean press, long press once
        b_p = press_cnt; b_l = long_cnt;
        touch_key = 1'b1;
        repeat (6) tick();
        chk("press_lat_lo", {31'd0, key_level}, 32'd0);
        tick();
        chk("press_lat_hi", {31'd0, key_level},   32'd1);
        chk("press_pulse",  {31'd0, press_pulse}, 32'd1);
        tick();
        chk("press_one_cyc", {31'd0, press_pulse}, 32'd0);
        repeat (18) tick();
        chk("long_early", {31'd0, long_pulse}, 32'd0);
        tick();
        chk("long_fire", {31'd0, long_pulse}, 32'd1);
        tick();
        chk("long_one_cyc", {31'd0, long_pulse}, 32'd0);
        repeat (20) tick();
        chk("long_once",  long_cnt - b_l,  32'd1);
        chk("press_once", press_cnt - b_p, 32'd1);

        // ---- bouncy release
        b_r = release_cnt;
        touch_key = 1'b0; repeat (2) tick();
        touch_key = 1'b1; tick();
        touch_key = 1'b0;
        repeat (6) tick();
        chk("bounce_level",  {31'd0, key_level}, 32'd1);
        chk("bounce_no_rel", release_cnt - b_r,  32'd0);
        tick();
        chk("rel_lat",   {31'd0, key_level},     32'd0);
        chk("rel_pulse", {31'd0, release_pulse}, 32'd1);
        tick();
        chk("rel_one_cyc", {31'd0, release_pulse}, 32'd0);
        repeat (3) tick();

        // ---- release bounce during long timing: hold time is frozen, not reset
        b_r = release_cnt;
        touch_key = 1'b1;
        repeat (7) tick();
        chk("p2_level", {31'd0, key_level}, 32'd1);
        repeat (3) tick();
        touch_key = 1'b0; repeat (2) tick();
        touch_key = 1'b1;
        repeat (16) tick();
        chk("frz_long_early", {31'd0, long_pulse}, 32'd0);
        chk("frz_level",      {31'd0, key_level},  32'd1);
        tick();
        chk("frz_long_fire", {31'd0, long_pulse}, 32'd1);
        chk("frz_no_rel",    release_cnt - b_r,   32'd0);
        touch_key = 1'b0;
        repeat (10) tick();

        // ---- short press: one press, one release, no long
        b_p = press_cnt; b_r = release_cnt; b_l = long_cnt;
        touch_key = 1'b1;
        repeat (10) tick();
        touch_key = 1'b0;
        repeat (6) tick();
        chk("short_level_hi", {31'd0, key_level}, 32'd1);
        tick();
        chk("short_rel_lat", {31'd0, key_level},     32'd0);
        chk("short_rel",     {31'd0, release_pulse}, 32'd1);
        repeat (30) tick();
        chk("short_press_n", press_cnt - b_p,   32'd1);
        chk("short_rel_n",   release_cnt - b_r, 32'd1);
        chk("short_no_long", long_cnt - b_l,    32'd0);

        // ---- glitches of 3 and 4 cycles rejected, 5 accepted
        b_p = press_cnt;
        touch_key = 1'b1; repeat (3) tick();
        touch_key = 1'b0; repeat (10) tick();
        chk("glitch3_level", {31'd0, key_level}, 32'd0);
        touch_key = 1'b1; repeat (4) tick();
        touch_key = 1'b0; repeat (10) tick();
        chk("glitch4_level", {31'd0, key_level}, 32'd0);
        chk("glitch_no_press", press_cnt - b_p, 32'd0);
        touch_key = 1'b1; repeat (5) tick();
        touch_key = 1'b0; repeat (20) tick();
        chk("run5_press", press_cnt - b_p, 32'd1);

        // ---- asynchronous reset in PRESS_DB, then re-debounce
        touch_key = 1'b1;
        repeat (3) tick();
        #2 sys_rst = 1'b1;
        #1 chk("rst_pdb_level", {31'd0, key_level}, 32'd0);
        tick();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (6) tick();
        chk("rst_pdb_lo", {31'd0, press_pulse}, 32'd0);
        tick();
        chk("rst_pdb_press", {31'd0, press_pulse}, 32'd1);

        // ---- asynchronous reset in HELD: outputs drop before any edge
        repeat (2) tick();
        chk("held_level", {31'd0, key_level}, 32'd1);
        #2 sys_rst = 1'b1;
        #1 chk("rst_held_async", {31'd0, key_level}, 32'd0);
        tick();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (6) tick();
        chk("rst_held_lo", {31'd0, key_level}, 32'd0);
        tick();
        chk("rst_held_press", {31'd0, press_pulse}, 32'd1);
        chk("rst_held_level", {31'd0, key_level},   32'd1);
        touch_key = 1'b0;
        repeat (20) tick();

        // ---- inverted polarity instance
        @(negedge sys_clk);
        rst_n2 = 1'b0;
        repeat (8) tick();
        chk("inv_quiet_level", {31'd0, level_n}, 32'd0);
        chk("inv_quiet_pulses", press_n_cnt + release_n_cnt + long_n_cnt, 32'd0);
        key_n = 1'b0;
        repeat (6) tick();
        chk("inv_lat_lo", {31'd0, level_n}, 32'd0);
        tick();
        chk("inv_lat_hi", {31'd0, level_n}, 32'd1);
        chk("inv_press",  {31'd0, press_n}, 32'd1);

        chk("pulse_overlap", overlap_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/touch_key_debounce.md
# touch_key_debounce

Conditioning stage between the raw `touch_key` pin and the touch-toggled LED controller.
- Synchronises the asynchronous touch-sensor output and rejects glitches shorter than a programmable debounce window.
- Emits a clean debounced level plus single-cycle press, release and long-press events.
- `key_level` is the drop-in replacement for the raw pin at the LED controller's input; the event pulses are for future consumers.

## Interface
- `DEBOUNCE_CYC`, default 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); legal range ≥ 2.
- `LONG_CYC`, default 50_000_000: cycles in HELD before `long_pulse` fires (1 s at 50 MHz); legal range ≥ 1.
- `ACTIVE_LVL`, default 1'b1: raw pin level meaning "touched".

Ports:
- `sys_clk` in 1: single system clock; all logic on its rising edge.
- `sys_rst` in 1: asynchronous, active-high reset.
- `touch_key` in 1: raw touch sensor output, asynchronous to `sys_clk`.
- `key_level` out 1: debounced state, 1 = touched, registered.
- `press_pulse` out 1: one-cycle pulse on accepted press, registered.
- `release_pulse` out 1: one-cycle pulse on accepted release, registered.
- `long_pulse` out 1: one-cycle pulse when a press has been held `LONG_CYC` cycles, registered.

## Operation
- **Synchroniser:** two-flop chain on `touch_key`; its second stage is `s`. Define `p = (s == ACTIVE_LVL)`.
- **Counters:**
  - `db_cnt`: width `$clog2(DEBOUNCE_CYC)`.
  - `hold_cnt`: width `$clog2(LONG_CYC+1)`.
  - Both are unsigned and never wrap.
- **FSM states:** IDLE, PRESS_DB, HELD, RELEASE_DB.
- **IDLE:**
  - `p`=1 → PRESS_DB, `db_cnt`←0.
- **PRESS_DB:**
  - `p`=0 → IDLE, `db_cnt`←0 (glitch rejected, no pulse).
  - `p`=1 and `db_cnt`==DEBOUNCE_CYC-1 → HELD, `key_level`←1, `press_pulse`←1, `hold_cnt`←0, `long_done`←0.
  - Otherwise `db_cnt`++.
- **HELD:**
  - `p`=0 → RELEASE_DB, `db_cnt`←0.
  - Independently, while `long_done`=0:
    - if `hold_cnt`==LONG_CYC-1 then `long_pulse`←1, `long_done`←1;
    - else `hold_cnt`++.
  - `long_done` limits `long_pulse` to at most one per accepted press.
- **RELEASE_DB:**
  - `p`=1 → HELD (bounce rejected, `key_level` stays 1, no pulse).
  - `p`=0 and `db_cnt`==DEBOUNCE_CYC-1 → IDLE, `key_level`←0, `release_pulse`←1.
  - Otherwise `db_cnt`++.
  - `hold_cnt` and `long_done` are frozen in this state, so a rejected release bounce does not restart long-press timing.
- **Pulses:** `press_pulse`, `release_pulse` and `long_pulse` are 0 every cycle they are not explicitly set. At most one pulse is high in any cycle.
- **Reset (`sys_rst`=1, any time including mid-debounce):**
  - state IDLE;
  - both synchroniser flops ←~ACTIVE_LVL;
  - `db_cnt`, `hold_cnt`, `long_done` ← 0;
  - all outputs ← 0.
  - A press in progress is discarded. After reset deassertion a held key is re-debounced from scratch.

## Timing
- **Press latency:** let edge k be the first edge that samples a touched `touch_key`. `key_level` and `press_pulse` go high after edge k+DEBOUNCE_CYC+2, given the pin stays touched throughout. `press_pulse` is high for exactly one cycle.
- **Release latency:** symmetric to press latency, DEBOUNCE_CYC+2 edges; `key_level` falls and `release_pulse` is high in the same cycle.
- **Long press:** `long_pulse` is asserted after the LONG_CYC-th edge following the edge that set `key_level`, provided the key is still in HELD/RELEASE_DB with cumulative HELD time ≥ LONG_CYC.
- **Glitch rejection:** any touched run shorter than DEBOUNCE_CYC+1 sampled cycles produces no output change.
- **Input timing:** no combinational path from `touch_key` to any output; `touch_key` needs no setup/hold relation to `sys_clk`.

## Test plan
Benches use DEBOUNCE_CYC=4, LONG_CYC=20, ACTIVE_LVL=1.
- **Clean press:** `touch_key` 0→1 held 30 cycles → `key_level` rises 6 edges after the sampling edge; single `press_pulse`; one `long_pulse` 20 cycles later, none after.
- **Glitch:** a 3-cycle high pulse on `touch_key` → `key_level` stays 0; no pulses.
- **Bouncy release:** from HELD, `touch_key` 1→0 for 2 cycles, 1 for 1 cycle, then 0 steady → no pulse during the bounce; `release_pulse` once, `key_level`=0 6 edges after steady 0 begins; `hold_cnt` not reset by the bounce.
- **Short press:** press held 10 cycles then released → `press_pulse` then `release_pulse` exactly once each; no `long_pulse`.
- **Reset mid-operation:** assert `sys_rst` asynchronously in PRESS_DB, and separately in HELD → outputs 0 immediately, without waiting for a clock edge; after deassertion with key still high, `press_pulse` re-occurs 6 edges later.
- **Inverted polarity:** ACTIVE_LVL=0, `touch_key` held 1 at reset and then driven 0 → `key_level`=1 after 6 edges; no spurious pulse out of reset.
